// File: rtl/dmem_defs.sv
// Shared definitions for the data-memory access controller: FSM encoding and defaults.
// The timeout path is built only when DMEM_CTRL_TIMEOUT_EN is defined.
package dmem_defs;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          TIMEOUT_CYC_DEF = 256;
    localparam logic [31:0] DMEM_ERR_DATA   = 32'h0;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clear / enable / terminal-count counter that bounds how long a bus request may wait.
// Present only when DMEM_CTRL_TIMEOUT_EN is defined; the default build has no timeout logic.
`ifdef DMEM_CTRL_TIMEOUT_EN
module dmem_timeout_cnt #(
    parameter int TERM = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = (TERM > 1) ? $clog2(TERM) : 1;

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == CNT_W'(TERM - 1));

endmodule
`endif

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory access controller: req/ack bus transaction, load return and pipeline stall.
// Optional request timeout with bus_err reporting is enabled by defining DMEM_CTRL_TIMEOUT_EN.
module dmem_ctrl
    import dmem_defs::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dmem_re,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] dmem_wd,
    output logic [DATA_W-1:0] rd,
    output logic              stall,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("dmem_ctrl: TIMEOUT_CYC must be at least 2");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_rd;
    logic              w_access;
    logic              w_aligned;
    logic              w_start;
    logic              w_timeout;
    logic              w_stall;
    logic              w_misalign;

    assign w_access  = dmem_re | dmem_we;
    assign w_aligned = (alu_out[1:0] == 2'b00);

`ifdef DMEM_CTRL_TIMEOUT_EN
    logic w_tc;
    logic r_bus_err;

    dmem_timeout_cnt #(
        .TERM (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clock (clock),
        .reset (reset),
        .i_clr (w_start),
        .i_en  ((r_state == S_REQ) && !bus_ack),
        .o_tc  (w_tc)
    );

    // An ack arriving in the terminal cycle still completes the access normally.
    assign w_timeout = (r_state == S_REQ) && w_tc && !bus_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access && w_aligned) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (w_access) begin
                    w_misalign  = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            // Strobes still high here belong to the instruction that just completed.
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_start) begin
            r_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
            r_wdata <= dmem_wd;
            r_we    <= dmem_we;
        end
    end

    // rd only ever changes on a completed load (or a timed-out access when enabled).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd <= '0;
        end else if ((r_state == S_REQ) && bus_ack && !r_we) begin
            r_rd <= bus_rdata;
`ifdef DMEM_CTRL_TIMEOUT_EN
        end else if (w_timeout) begin
            r_rd <= DATA_W'(DMEM_ERR_DATA);
`endif
        end
    end

    assign rd           = r_rd;
    assign stall        = w_stall;
    assign misalign_err = w_misalign;
    assign bus_req      = (r_state == S_REQ);
    assign bus_we       = r_we;
    assign bus_addr     = r_addr;
    assign bus_wdata    = r_wdata;

endmodule
